// File: rtl/qmath_pkg.sv
// qmath_pkg: shared state type and fixed-point helpers for the qmath divider/multiplier family
package qmath_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIN, HOLD} state_t;
  function automatic int calc_shift(input int qa, input int qb, input int qq);
    return qq - qa + qb;
  endfunction
  function automatic int calc_dw(input int na, input int sh);
    return na + sh;
  endfunction
  // Unsigned magnitude of a w-bit two's-complement value; the most-negative input maps exactly.
  function automatic logic [63:0] mag(input logic [63:0] x, input int unsigned w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return x[w-1] ? ((~x + 64'd1) & m) : (x & m);
  endfunction
  function automatic logic [63:0] sat_val(input logic [63:0] m, input logic neg, input int unsigned n);
    logic [63:0] lim;
    logic [63:0] msk;
    lim = 64'd1 << (n - 1);
    msk = (lim << 1) - 64'd1;
    if (m == '0) return '0;
    if (neg) return (m > lim) ? lim : ((~m + 64'd1) & msk);
    return (m >= lim) ? (lim - 64'd1) : m;
  endfunction
  function automatic logic sat_ovf(input logic [63:0] m, input logic neg, input int unsigned n);
    logic [63:0] lim;
    lim = 64'd1 << (n - 1);
    return (m != '0) && (neg ? (m > lim) : (m >= lim));
  endfunction
endpackage

// File: rtl/qdiv_seq.sv
// qdiv_seq: sequential restoring radix-2 signed fixed-point divider, q = a / b
module qdiv_seq
  import qmath_pkg::*;
#(
  parameter int Q_a = 8,
  parameter int N_a = 16,
  parameter int Q_b = 10,
  parameter int N_b = 16,
  parameter int Q_q = 12,
  parameter int N_q = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_a-1:0] a,
  input  logic [N_b-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_q-1:0] q_result,
  output logic           overflow,
  output logic           div_zero
);
  localparam int SHIFT = calc_shift(Q_a, Q_b, Q_q);
  localparam int DW = calc_dw(N_a, SHIFT);
  localparam int CW = $clog2(DW);

  if (SHIFT < 0) begin : g_shift_chk
    $error("qdiv_seq: Q_q - Q_a + Q_b must be non-negative");
  end

  state_t state_q, state_d;
  logic sign_q, sign_d, azero_q, azero_d;
  logic [DW-1:0] dvd_q, dvd_d, quo_q, quo_d;
  logic [N_b-1:0] div_q, div_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_q-1:0] q_q, q_d;
  logic ovf_q, ovf_d, dz_q, dz_d, ov_q, ov_d, ir_q, ir_d;
  logic [N_a-1:0] a_mag;
  logic [N_b-1:0] b_mag;
  logic [N_b:0] rem_sh;
  logic ge;
  logic [63:0] qm;

  assign in_ready = ir_q;
  assign out_valid = ov_q;
  assign q_result = q_q;
  assign overflow = ovf_q;
  assign div_zero = dz_q;

  always_comb begin
    a_mag = N_a'(mag(64'(a), N_a));
    b_mag = N_b'(mag(64'(b), N_b));
    rem_sh = {rem_q, dvd_q[DW-1]};
    ge = rem_sh >= {1'b0, div_q};
    qm = azero_q ? '0 : 64'(quo_q);
    state_d = state_q;
    sign_d = sign_q;
    azero_d = azero_q;
    dvd_d = dvd_q;
    quo_d = quo_q;
    div_d = div_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    q_d = q_q;
    ovf_d = ovf_q;
    dz_d = dz_q;
    ov_d = ov_q;
    ir_d = ir_q;
    case (state_q)
      IDLE: if (in_valid && ir_q) begin
        state_d = CALC;
        ir_d = 1'b0;
        sign_d = a[N_a-1] ^ b[N_b-1];
        azero_d = a == '0;
        dvd_d = DW'(a_mag) << SHIFT;
        div_d = b_mag;
        rem_d = '0;
        quo_d = '0;
        cnt_d = CW'(DW - 1);
      end
      CALC: begin
        dvd_d = dvd_q << 1;
        rem_d = N_b'(ge ? rem_sh - {1'b0, div_q} : rem_sh);
        quo_d = {quo_q[DW-2:0], ge};
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? FIN : CALC;
      end
      FIN: begin
        q_d = N_q'(sat_val(qm, sign_q, N_q));
        ovf_d = sat_ovf(qm, sign_q, N_q);
        dz_d = div_q == '0;
        ov_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (out_ready) begin
        state_d = IDLE;
        ov_d = 1'b0;
        ir_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      azero_q <= 1'b0;
      dvd_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      q_q <= '0;
      ovf_q <= 1'b0;
      dz_q <= 1'b0;
      ov_q <= 1'b0;
      ir_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      azero_q <= azero_d;
      dvd_q <= dvd_d;
      quo_q <= quo_d;
      div_q <= div_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      ovf_q <= ovf_d;
      dz_q <= dz_d;
      ov_q <= ov_d;
      ir_q <= ir_d;
    end
  end
endmodule

// File: tb/tb_qdiv_seq.sv
// tb_qdiv_seq: scoreboard bench for qdiv_seq with directed, hand-computed vectors
module tb_qdiv_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, overflow, div_zero;
  logic [15:0] q_result;

  qdiv_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .q_result(q_result),
    .overflow(overflow), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] q; logic o; logic z; int acc;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: latency checked on the rising out_valid, data checked on the output handshake.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL stale_valid: got out_valid=1 expected no result pending");
      end else chk("latency", cyc - sb[0].acc, 31);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got q_result=%0h expected no result", q_result);
      end else begin
        e = sb.pop_front();
        chk("q_result", q_result, e.q);
        chk("overflow", overflow, e.o);
        chk("div_zero", div_zero, e.z);
      end
    end
    ov_prev <= out_valid;
  end

  task automatic issue(input logic [15:0] ai, input logic [15:0] bi, input logic [15:0] qi,
                       input logic oi, input logic zi);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_err++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 100 cycles");
      return;
    end
    a = ai;
    b = bi;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sb.push_back('{q: qi, o: oi, z: zi, acc: cyc});
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q_result", q_result, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_div_zero", div_zero, 0);
    rst = 1'b0;
    issue(16'h0100, 16'h0200, 16'h2000, 0, 0);
    issue(16'hFE80, 16'h0100, 16'hA000, 0, 0);
    issue(16'hF800, 16'h0400, 16'h8000, 0, 0);
    issue(16'h0001, 16'h0C00, 16'h0005, 0, 0);
    issue(16'hFFFF, 16'h0C00, 16'hFFFB, 0, 0);
    issue(16'h6400, 16'h0200, 16'h7FFF, 1, 0);
    issue(16'h8000, 16'hFC00, 16'h7FFF, 1, 0);
    issue(16'h0100, 16'h0000, 16'h7FFF, 1, 1);
    issue(16'hFF00, 16'h0000, 16'h8000, 1, 1);
    issue(16'h0000, 16'h0000, 16'h0000, 0, 1);
    drain();
    // Back-pressure: hold the result, then release with a single-cycle out_ready pulse.
    out_ready = 1'b0;
    issue(16'h0100, 16'h0200, 16'h2000, 0, 0);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("hold_arrived", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_q_result", q_result, 16'h2000);
    end
    @(posedge clk) #1 out_ready = 1'b1;
    @(posedge clk) #1 out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
    drain();
    out_ready = 1'b1;
    // Reset mid-CALC must discard the operation.
    issue(16'h0300, 16'h0100, 16'h3000, 0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_q_result", q_result, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_div_zero", div_zero, 0);
    repeat (40) @(negedge clk);
    chk("abort_no_result", out_valid, 0);
    issue(16'h0001, 16'h0C00, 16'h0005, 0, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
